// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline control blocks.
//   REG_ADDR_WIDTH : register-file address width
//   REG_X0         : address of the hard-wired zero register
//   stall_state_e  : per-cycle stall class reported by the hazard controller
package riscv_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        DRAIN      = 2'd3
    } stall_state_e;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side, drives hazard inputs and consumes stall/flush controls
//   slave  : hazard controller side
interface hazard_stall_controller_if
    import riscv_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
);
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic                      id_uses_rs1;
    logic                      id_uses_rs2;
    logic                      id_fence;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_mem_read;
    logic                      ex_branch_taken;
    logic                      ex_valid;
    logic                      mem_valid;
    logic                      wb_valid;
    logic                      mem_busy;

    logic                      pc_write_enable;
    logic                      if_id_write_enable;
    logic                      if_id_flush;
    logic                      id_ex_bubble;
    logic                      pipeline_freeze;
    logic [1:0]                stall_state;
    logic                      mem_timeout_error;
    logic [COUNTER_WIDTH-1:0]  stall_cycle_count;
    logic [COUNTER_WIDTH-1:0]  flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_fence,
               ex_rd, ex_mem_read, ex_branch_taken,
               ex_valid, mem_valid, wb_valid, mem_busy,
        input  pc_write_enable, if_id_write_enable, if_id_flush, id_ex_bubble,
               pipeline_freeze, stall_state, mem_timeout_error,
               stall_cycle_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_fence,
               ex_rd, ex_mem_read, ex_branch_taken,
               ex_valid, mem_valid, wb_valid, mem_busy,
        output pc_write_enable, if_id_write_enable, if_id_flush, id_ex_bubble,
               pipeline_freeze, stall_state, mem_timeout_error,
               stall_cycle_count, flush_count
    );

endinterface

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones.
//   clk   : clock
//   clear : synchronous clear, wins over inc
//   inc   : count enable
//   count : current value
module saturating_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline. Covers load-use,
// taken-branch redirect, data-memory wait states and FENCE drain, and keeps
// saturating stall/flush performance counters.
//   clk : pipeline clock
//   rst : synchronous active-high reset
//   bus : hazard inputs in, stall/flush controls and status out
//
// state      | meaning
// RUN        | normal flow (also recorded for a flush cycle)
// LOAD_STALL | one-cycle bubble behind a load whose result ID needs
// MEM_WAIT   | data memory busy, everything past IF/ID frozen
// DRAIN      | FENCE in ID waiting for EX/MEM/WB to empty
module hazard_stall_controller
    import riscv_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_stall_controller_if.slave bus
);

    localparam int MW_WIDTH = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [MW_WIDTH-1:0] MW_LAST = MW_WIDTH'(MEM_TIMEOUT - 1);

    stall_state_e             state_q;
    stall_state_e             state_next;
    logic                     load_use;
    logic                     drain;
    logic                     flush_cycle;
    logic                     timeout_q;
    logic [MW_WIDTH-1:0]      mw_count;
    logic [COUNTER_WIDTH-1:0] stall_count;
    logic [COUNTER_WIDTH-1:0] flush_cnt;

    always_comb begin
        load_use = bus.ex_mem_read && (bus.ex_rd != REG_X0) &&
                   ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
        drain    = bus.id_fence && (bus.ex_valid || bus.mem_valid || bus.wb_valid);
    end

    always_comb begin
        state_next             = RUN;
        flush_cycle            = 1'b0;
        bus.pc_write_enable    = 1'b1;
        bus.if_id_write_enable = 1'b1;
        bus.if_id_flush        = 1'b0;
        bus.id_ex_bubble       = 1'b0;
        bus.pipeline_freeze    = 1'b0;

        if (bus.mem_busy) begin
            // A taken branch waits here; it is flushed once memory releases.
            state_next             = MEM_WAIT;
            bus.pc_write_enable    = 1'b0;
            bus.if_id_write_enable = 1'b0;
            bus.pipeline_freeze    = 1'b1;
        end else if (bus.ex_branch_taken) begin
            flush_cycle      = 1'b1;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end else if (load_use || drain) begin
            state_next             = load_use ? LOAD_STALL : DRAIN;
            bus.pc_write_enable    = 1'b0;
            bus.if_id_write_enable = 1'b0;
            bus.id_ex_bubble       = 1'b1;
        end

        if (rst) begin
            flush_cycle            = 1'b0;
            bus.pc_write_enable    = 1'b0;
            bus.if_id_write_enable = 1'b0;
            bus.if_id_flush        = 1'b1;
            bus.id_ex_bubble       = 1'b1;
            bus.pipeline_freeze    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_next;
        end
    end

    // The error rises on the edge that brings the wait count to MEM_TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (bus.mem_busy && (mw_count >= MW_LAST)) begin
            timeout_q <= 1'b1;
        end
    end

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_counter (
        .clk   (clk),
        .clear (rst),
        .inc   (!bus.pc_write_enable),
        .count (stall_count)
    );

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_counter (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_cycle),
        .count (flush_cnt)
    );

    saturating_counter #(.WIDTH(MW_WIDTH)) u_mem_wait_counter (
        .clk   (clk),
        .clear (rst || !bus.mem_busy),
        .inc   (bus.mem_busy),
        .count (mw_count)
    );

    assign bus.stall_state       = state_q;
    assign bus.mem_timeout_error = timeout_q;
    assign bus.stall_cycle_count = stall_count;
    assign bus.flush_count       = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (COUNTER_WIDTH=4, MEM_TIMEOUT=4).
module tb_hazard_stall_controller;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    hazard_stall_controller_if #(.COUNTER_WIDTH(CW)) bus ();

    hazard_stall_controller #(
        .COUNTER_WIDTH (CW),
        .MEM_TIMEOUT   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = '0;          bus.id_rs2 = '0;
        bus.id_uses_rs1 = 1'b0;   bus.id_uses_rs2 = 1'b0;
        bus.id_fence = 1'b0;      bus.ex_rd = '0;
        bus.ex_mem_read = 1'b0;   bus.ex_branch_taken = 1'b0;
        bus.ex_valid = 1'b0;      bus.mem_valid = 1'b0;
        bus.wb_valid = 1'b0;      bus.mem_busy = 1'b0;
    endtask

    // Checks pc_we, if_id_we, flush, bubble, freeze as one 5-bit vector.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {27'd0, bus.pc_write_enable, bus.if_id_write_enable, bus.if_id_flush,
                  bus.id_ex_bubble, bus.pipeline_freeze}, {27'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_FREEZE = 5'b00001;
    localparam logic [4:0] C_RST   = 5'b00110;

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk_ctl("reset_ctl", C_RST);
        rst = 1'b0;
        chk_ctl("run_after_reset", C_RUN);
        chk("reset_state", bus.stall_state, 0);
        chk("reset_stall_cnt", bus.stall_cycle_count, 0);
        chk("reset_flush_cnt", bus.flush_count, 0);
        chk("reset_err", bus.mem_timeout_error, 0);

        // load-use via rs2
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
        chk_ctl("load_use_ctl", C_STALL);
        step();
        idle_inputs();
        chk_ctl("load_use_over", C_RUN);
        chk("load_use_state", bus.stall_state, 1);
        chk("load_use_cnt", bus.stall_cycle_count, 1);
        step();
        chk("load_use_state_back", bus.stall_state, 0);

        // load to x0
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
        chk_ctl("x0_no_stall", C_RUN);
        step();
        chk("x0_state", bus.stall_state, 0);
        chk("x0_cnt", bus.stall_cycle_count, 1);

        // rs1 match but rs1 not used, then used
        bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_uses_rs1 = 1'b0;
        chk_ctl("rs1_unused", C_RUN);
        bus.id_uses_rs1 = 1'b1;
        chk_ctl("rs1_used", C_STALL);
        step();
        idle_inputs();
        chk("rs1_cnt", bus.stall_cycle_count, 2);

        // branch overriding load-use
        bus.ex_branch_taken = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
        chk_ctl("branch_over_load", C_FLUSH);
        step();
        idle_inputs();
        chk("branch_flush_cnt", bus.flush_count, 1);
        chk("branch_stall_cnt", bus.stall_cycle_count, 2);
        chk("branch_state", bus.stall_state, 0);

        // memory wait holding a taken branch
        bus.ex_branch_taken = 1'b1;
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_ctl($sformatf("mem_wait_%0d", i), C_FREEZE);
            step();
        end
        bus.mem_busy = 1'b0;
        chk_ctl("mem_wait_release_flush", C_FLUSH);
        chk("mem_wait_state", bus.stall_state, 2);
        chk("mem_wait_stall_cnt", bus.stall_cycle_count, 6);
        chk("mem_wait_flush_cnt_before", bus.flush_count, 1);
        step();
        idle_inputs();
        chk("mem_wait_flush_cnt", bus.flush_count, 2);
        chk("flush_state_is_run", bus.stall_state, 0);

        // timeout: interrupted wait does not accumulate
        do_reset();
        chk("to_reset_err", bus.mem_timeout_error, 0);
        bus.mem_busy = 1'b1;
        repeat (3) step();
        bus.mem_busy = 1'b0;
        step();
        bus.mem_busy = 1'b1;
        repeat (3) step();
        chk("to_interrupted", bus.mem_timeout_error, 0);
        step();
        chk("to_rises_4th", bus.mem_timeout_error, 1);
        bus.mem_busy = 1'b0;
        repeat (3) step();
        chk("to_sticky", bus.mem_timeout_error, 1);
        do_reset();
        chk("to_cleared", bus.mem_timeout_error, 0);

        // FENCE drain
        bus.id_fence = 1'b1;
        bus.ex_valid = 1'b1; bus.mem_valid = 1'b1; bus.wb_valid = 1'b1;
        chk_ctl("drain_1", C_STALL);
        step();
        bus.ex_valid = 1'b0;
        chk_ctl("drain_2", C_STALL);
        chk("drain_state", bus.stall_state, 3);
        step();
        bus.mem_valid = 1'b0;
        chk_ctl("drain_3", C_STALL);
        step();
        bus.wb_valid = 1'b0;
        chk_ctl("drain_done", C_RUN);
        chk("drain_cnt", bus.stall_cycle_count, 3);
        step();
        idle_inputs();
        chk("drain_state_run", bus.stall_state, 0);

        // FENCE drain abandoned by reset in drain cycle 2
        do_reset();
        bus.id_fence = 1'b1;
        bus.ex_valid = 1'b1; bus.mem_valid = 1'b1; bus.wb_valid = 1'b1;
        step();
        bus.ex_valid = 1'b0;
        chk("middrain_cnt", bus.stall_cycle_count, 1);
        rst = 1'b1;
        chk_ctl("middrain_rst_ctl", C_RST);
        step();
        rst = 1'b0;
        idle_inputs();
        chk("middrain_state", bus.stall_state, 0);
        chk("middrain_stall_cnt", bus.stall_cycle_count, 0);
        chk("middrain_flush_cnt", bus.flush_count, 0);
        chk_ctl("middrain_run", C_RUN);

        // counter saturation at all-ones
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b1;
        repeat (15) step();
        chk("stall_sat_15", bus.stall_cycle_count, 15);
        repeat (5) step();
        chk("stall_sat_hold", bus.stall_cycle_count, 15);
        bus.ex_branch_taken = 1'b1;
        repeat (17) step();
        idle_inputs();
        chk("flush_sat", bus.flush_count, 15);
        chk("stall_sat_after_flush", bus.stall_cycle_count, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
